step_pulse_gen: RTL and testbench
=================================

Name: step_pulse_gen

Overview:
Step-rate generator, the transmit-side counterpart of the speed measurement path: converts a commanded speed into a train of step pulses that a downstream speed measurement sees as that speed. The block is a numerically controlled oscillator (phase accumulator) driven by a base tick, with slew-rate-limited ramping toward the target on the measurement time base. It sits between the motor control loop (target and acceleration) and the step/drive output stage.

Parameters:
K_WIDTH, 32, width of speed, step-size and acceleration quantities.
PULSE_WIDTH, 4, o_step high time in i_clk cycles (>=1).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active high
i_tick  in  1  accumulation strobe; base sample rate
i_time_trigger  in  1  ramp update strobe; same time base as the measurement window
i_target  in  K_WIDTH  target speed, units per tick
i_accel  in  K_WIDTH  max speed change per i_time_trigger; 0 = jump directly to target
i_step_size  in  K_WIDTH  units represented by one output pulse
i_enable  in  1  run request; low requests ramp-down to stop
i_force_stop  in  1  immediate stop, no ramp
o_step  out  1  step pulse, PULSE_WIDTH cycles high
o_speed  out  K_WIDTH  currently applied speed
o_running  out  1  high in RUN or STOPPING
o_at_target  out  1  high in RUN when o_speed == i_target
o_overrun  out  1  sticky: pulse request dropped

Behaviour:
- Reset (i_rst high at clock edge): state IDLE, accumulator 0, o_speed 0, o_step 0, pulse counter 0, o_running 0, o_at_target 0, o_overrun 0. All outputs registered.
- FSM states: IDLE, RUN, STOPPING.
- IDLE: o_speed 0, accumulator 0. i_enable high -> RUN next cycle. o_overrun cleared on the IDLE->RUN transition.
- RUN: on i_time_trigger, o_speed moves toward i_target by at most i_accel (i_accel=0: o_speed <= i_target); no overshoot. i_enable low -> STOPPING.
- STOPPING: effective target 0, same ramp rule. When o_speed == 0 -> IDLE, accumulator cleared. i_enable high again -> RUN, no reset of o_speed.
- i_force_stop: priority over everything except reset. From any state -> IDLE next cycle. o_speed 0, accumulator 0, o_step 0 and pulse counter 0 on that edge.
- NCO, only in RUN/STOPPING, on i_tick: sum = acc + o_speed, K_WIDTH+1 bits. If i_step_size != 0 and sum >= i_step_size: request pulse, acc <= sum - i_step_size, otherwise acc <= sum.
- At most one pulse per tick. If the remainder is still >= i_step_size, acc saturates to i_step_size-1 and o_overrun sets.
- i_step_size == 0: no pulses, acc held.
- Pulse: a request starts o_step high on the next cycle for exactly PULSE_WIDTH cycles. A request while o_step is high is dropped and sets o_overrun.
- i_tick and i_time_trigger in the same cycle: accumulation uses o_speed before the ramp update.
- Parameter changes (i_target, i_accel, i_step_size) take effect on the next strobe. No latching.
- o_at_target is registered from the next-state values (state RUN and next o_speed == i_target).

Decomposition:
- Shared motor package gets typedef spg_state_e {IDLE, RUN, STOPPING}.
- Shared motor package gets a K_WIDTH-generic speed typedef shared with the measurement path.
- Natural sub-module: pulse_stretcher (trigger in, PULSE_WIDTH-cycle output, busy flag). The FSM, ramp and NCO stay in step_pulse_gen.

Test Plan:
- Basic rate: i_tick every cycle, i_accel=0, i_step_size=10, i_target=5, i_enable=1, one i_time_trigger -> o_speed=5, then o_step rising edge every 2 ticks. PULSE_WIDTH=1 for this run.
- Ramp up and down: i_accel=2, i_target=7, 5 time triggers -> o_speed 2,4,6,7,7 and o_at_target high after the 4th. Then i_enable=0 -> o_speed 5,3,1,0, then IDLE, o_running low.
- Force stop mid-pulse: o_speed=100, o_step high, assert i_force_stop for 1 cycle -> next cycle o_step=0, o_speed=0, state IDLE. No pulse for the following 20 ticks.
- Overrun: i_step_size=4, o_speed=12, i_tick every cycle -> one pulse per tick max, accumulator held at 3, o_overrun=1. o_overrun stays set through i_enable low/high until the IDLE->RUN transition.
- Pulse collision: PULSE_WIDTH=4, i_step_size=1, o_speed=1, tick every cycle -> requests during the high phase dropped, o_overrun=1, o_step period 4+1 cycles.
- Loopback: feed o_step into the speed measurement block with the same i_step_size and window 100 ticks, o_speed=3, i_step_size=6 -> measured value 300 ±i_step_size. Also check synchronous i_rst mid-run returns all outputs to reset values on the same edge.

Source files
------------

// File: rtl/step_pulse_gen_pkg.sv
// step_pulse_gen_pkg
//   Shared motor-control types for the step generator and the speed
//   measurement path: FSM state encoding, the default speed width and the
//   speed typedef that both sides exchange.
package step_pulse_gen_pkg;

   localparam int SPG_K_WIDTH = 32;

   // Speed / step-size / acceleration quantity at the default width.
   typedef logic [SPG_K_WIDTH-1:0] spg_speed_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } spg_state_e;

   // The generator is "running" whenever it can still emit pulses.
   function automatic logic spg_is_active(input spg_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if
//   Control/status bundle between the motor control loop (master) and the
//   step pulse generator (slave).
//   Control : i_tick, i_time_trigger, i_target, i_accel, i_step_size,
//             i_enable, i_force_stop
//   Status  : o_step, o_speed, o_running, o_at_target, o_overrun
interface step_pulse_gen_if #(
   parameter int K_WIDTH = step_pulse_gen_pkg::SPG_K_WIDTH
) ();
   import step_pulse_gen_pkg::*;

   logic               i_tick;
   logic               i_time_trigger;
   logic [K_WIDTH-1:0] i_target;
   logic [K_WIDTH-1:0] i_accel;
   logic [K_WIDTH-1:0] i_step_size;
   logic               i_enable;
   logic               i_force_stop;

   logic               o_step;
   logic [K_WIDTH-1:0] o_speed;
   logic               o_running;
   logic               o_at_target;
   logic               o_overrun;

   modport master (
      output i_tick, i_time_trigger, i_target, i_accel, i_step_size,
             i_enable, i_force_stop,
      input  o_step, o_speed, o_running, o_at_target, o_overrun
   );

   modport slave (
      input  i_tick, i_time_trigger, i_target, i_accel, i_step_size,
             i_enable, i_force_stop,
      output o_step, o_speed, o_running, o_at_target, o_overrun
   );

endinterface

// File: rtl/step_pulse_gen_pulse_stretcher.sv
// step_pulse_gen_pulse_stretcher
//   Turns a one-cycle trigger into an output pulse exactly PULSE_WIDTH
//   cycles long, starting the cycle after the trigger. Triggers arriving
//   while the pulse is high are ignored here; the parent sees o_busy and
//   decides what to do about them.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : abort any pulse in progress immediately
//   i_trigger    : pulse request
//   o_pulse      : stretched pulse (registered)
//   o_busy       : pulse currently high, a trigger now would be lost
module step_pulse_gen_pulse_stretcher import step_pulse_gen_pkg::*; #(
   parameter int PULSE_WIDTH = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_trigger,
   output logic o_pulse,
   output logic o_busy
);

   localparam int CNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of high cycles still to come after this one.
   always_comb begin
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      if (i_clear) begin
         pulse_d = 1'b0;
         cnt_d   = '0;
      end else if (pulse_q) begin
         if (cnt_q == '0) begin
            pulse_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (i_trigger) begin
         pulse_d = 1'b1;
         cnt_d   = CNT_W'(PULSE_WIDTH - 1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_pulse = pulse_q;
   assign o_busy  = pulse_q;

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Step-rate generator: a phase accumulator advanced by the applied speed
//   on every i_tick emits one step request each time it crosses
//   i_step_size; the applied speed slews toward the target by at most
//   i_accel per i_time_trigger.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : control inputs and status outputs, see step_pulse_gen_if
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | stopped, speed and accumulator held at 0
//   RUN      | ramping toward / holding i_target, NCO active
//   STOPPING | ramping toward 0, NCO active; enters IDLE once speed is 0
module step_pulse_gen import step_pulse_gen_pkg::*; #(
   parameter int K_WIDTH     = SPG_K_WIDTH,
   parameter int PULSE_WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   step_pulse_gen_if.slave  bus
);

   spg_state_e         state_q, state_d;
   logic [K_WIDTH-1:0] speed_q, speed_d;
   logic [K_WIDTH-1:0] acc_q, acc_d;
   logic               running_q, running_d;
   logic               at_target_q, at_target_d;
   logic               overrun_q, overrun_d;

   logic               pulse_req;
   logic               nco_ovf;
   logic               overrun_clr;
   logic               step_busy;
   logic               step_out;
   logic [K_WIDTH-1:0] goal;
   logic [K_WIDTH:0]   sum;
   logic [K_WIDTH:0]   rem;
   logic [K_WIDTH:0]   step_ext;

   // Move cur toward tgt by at most max_step without overshooting;
   // max_step == 0 means jump straight to the target.
   function automatic logic [K_WIDTH-1:0] ramp_toward(
      input logic [K_WIDTH-1:0] cur,
      input logic [K_WIDTH-1:0] tgt,
      input logic [K_WIDTH-1:0] max_step
   );
      if (max_step == '0) begin
         return tgt;
      end else if (cur < tgt) begin
         return ((tgt - cur) > max_step) ? (cur + max_step) : tgt;
      end else begin
         return ((cur - tgt) > max_step) ? (cur - max_step) : tgt;
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      speed_d     = speed_q;
      acc_d       = acc_q;
      pulse_req   = 1'b0;
      nco_ovf     = 1'b0;
      overrun_clr = 1'b0;
      goal        = (state_q == RUN) ? bus.i_target : '0;
      step_ext    = {1'b0, bus.i_step_size};
      // One bit wider than the operands so the crossing test cannot wrap.
      sum         = {1'b0, acc_q} + {1'b0, speed_q};
      rem         = sum - step_ext;

      if (bus.i_force_stop) begin
         state_d = IDLE;
         speed_d = '0;
         acc_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               speed_d = '0;
               acc_d   = '0;
               if (bus.i_enable) begin
                  state_d     = RUN;
                  overrun_clr = 1'b1;
               end
            end
            RUN, STOPPING: begin
               if ((state_q == STOPPING) && !bus.i_enable && (speed_q == '0)) begin
                  state_d = IDLE;
                  acc_d   = '0;
               end else begin
                  // Accumulation uses the speed from before any ramp update
                  // happening in the same cycle.
                  if (bus.i_tick && (bus.i_step_size != '0)) begin
                     if (sum >= step_ext) begin
                        pulse_req = 1'b1;
                        if (rem >= step_ext) begin
                           // Speed exceeds one step per tick: pin the phase
                           // just below the next crossing and flag it.
                           acc_d   = bus.i_step_size - K_WIDTH'(1);
                           nco_ovf = 1'b1;
                        end else begin
                           acc_d = rem[K_WIDTH-1:0];
                        end
                     end else begin
                        acc_d = sum[K_WIDTH-1:0];
                     end
                  end
                  if (bus.i_time_trigger) begin
                     speed_d = ramp_toward(speed_q, goal, bus.i_accel);
                  end
                  state_d = bus.i_enable ? RUN : STOPPING;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (overrun_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q | nco_ovf | (pulse_req & step_busy);
      end
      running_d   = spg_is_active(state_d);
      at_target_d = (state_d == RUN) && (speed_d == bus.i_target);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         speed_q     <= '0;
         acc_q       <= '0;
         running_q   <= 1'b0;
         at_target_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         speed_q     <= speed_d;
         acc_q       <= acc_d;
         running_q   <= running_d;
         at_target_q <= at_target_d;
         overrun_q   <= overrun_d;
      end
   end

   step_pulse_gen_pulse_stretcher #(
      .PULSE_WIDTH (PULSE_WIDTH)
   ) u_stretch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (bus.i_force_stop),
      .i_trigger (pulse_req),
      .o_pulse   (step_out),
      .o_busy    (step_busy)
   );

   assign bus.o_step      = step_out;
   assign bus.o_speed     = speed_q;
   assign bus.o_running   = running_q;
   assign bus.o_at_target = at_target_q;
   assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen
//   Two generators (pulse width 1 and 4) driven by identical stimulus and
//   compared every cycle against a behavioural model, plus directed checks
//   of the ramp, force-stop, overrun, collision and loopback scenarios.
module tb_step_pulse_gen;
   import step_pulse_gen_pkg::*;

   localparam int M_OFF   = 0;
   localparam int M_ON    = 1;
   localparam int M_DRAIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       tick = 1'b0, trig = 1'b0, en = 1'b0, frc = 1'b0;
   spg_speed_t target = '0, accel = '0, step_sz = '0;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int     m_mode     = M_OFF;
   longint m_speed    = 0;
   longint m_acc      = 0;
   longint cyc        = 0;
   longint m_until[2] = '{-1, -1};  // last cycle each output is high
   bit     m_ovr[2]   = '{1'b0, 1'b0};
   int     pw[2]      = '{1, 4};

   bit prev1 = 1'b0, prev4 = 1'b0, rise1 = 1'b0, rise4 = 1'b0;

   step_pulse_gen_if #(.K_WIDTH(SPG_K_WIDTH)) bus1 ();
   step_pulse_gen_if #(.K_WIDTH(SPG_K_WIDTH)) bus4 ();

   assign bus1.i_tick = tick;           assign bus4.i_tick = tick;
   assign bus1.i_time_trigger = trig;   assign bus4.i_time_trigger = trig;
   assign bus1.i_target = target;       assign bus4.i_target = target;
   assign bus1.i_accel = accel;         assign bus4.i_accel = accel;
   assign bus1.i_step_size = step_sz;   assign bus4.i_step_size = step_sz;
   assign bus1.i_enable = en;           assign bus4.i_enable = en;
   assign bus1.i_force_stop = frc;      assign bus4.i_force_stop = frc;

   step_pulse_gen #(.K_WIDTH(SPG_K_WIDTH), .PULSE_WIDTH(1)) dut1 (
      .i_clk (clk), .i_rst (rst), .bus (bus1.slave)
   );
   step_pulse_gen #(.K_WIDTH(SPG_K_WIDTH), .PULSE_WIDTH(4)) dut4 (
      .i_clk (clk), .i_rst (rst), .bus (bus4.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_update();
      bit     req;
      longint tg, ac, st, goal, s, r;
      tg  = target;
      ac  = accel;
      st  = step_sz;
      req = 1'b0;
      cyc++;
      if (rst) begin
         m_mode = M_OFF; m_speed = 0; m_acc = 0;
         m_until[0] = -1; m_until[1] = -1;
         m_ovr[0] = 1'b0; m_ovr[1] = 1'b0;
         return;
      end
      if (frc) begin
         m_mode = M_OFF; m_speed = 0; m_acc = 0;
         m_until[0] = -1; m_until[1] = -1;
      end else if (m_mode == M_OFF) begin
         m_speed = 0; m_acc = 0;
         if (en) begin
            m_mode = M_ON;
            m_ovr[0] = 1'b0; m_ovr[1] = 1'b0;
         end
      end else if (m_mode == M_DRAIN && !en && m_speed == 0) begin
         m_mode = M_OFF; m_acc = 0;
      end else begin
         goal = (m_mode == M_ON) ? tg : 0;
         if (tick && st != 0) begin
            s = m_acc + m_speed;
            if (s >= st) begin
               req = 1'b1;
               r = s - st;
               if (r >= st) begin
                  m_acc = st - 1;
                  m_ovr[0] = 1'b1; m_ovr[1] = 1'b1;
               end else m_acc = r;
            end else m_acc = s;
         end
         if (trig) begin
            if (ac == 0) m_speed = goal;
            else if (m_speed < goal) m_speed = (m_speed + ac > goal) ? goal : m_speed + ac;
            else m_speed = (m_speed - ac < goal) ? goal : m_speed - ac;
         end
         m_mode = en ? M_ON : M_DRAIN;
      end
      for (int i = 0; i < 2; i++) begin
         if (req) begin
            if (cyc - 1 <= m_until[i]) m_ovr[i] = 1'b1;
            else m_until[i] = cyc + pw[i] - 1;
         end
      end
   endtask

   task automatic check_all();
      logic exp_at;
      exp_at = (m_mode == M_ON) && (m_speed == longint'(target));
      chk("speed_pw1", bus1.o_speed, m_speed);
      chk("speed_pw4", bus4.o_speed, m_speed);
      chk("running_pw1", bus1.o_running, m_mode != M_OFF);
      chk("running_pw4", bus4.o_running, m_mode != M_OFF);
      chk("at_target_pw1", bus1.o_at_target, exp_at);
      chk("at_target_pw4", bus4.o_at_target, exp_at);
      chk("step_pw1", bus1.o_step, cyc <= m_until[0]);
      chk("step_pw4", bus4.o_step, cyc <= m_until[1]);
      chk("overrun_pw1", bus1.o_overrun, m_ovr[0]);
      chk("overrun_pw4", bus4.o_overrun, m_ovr[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
      check_all();
      rise1 = (bus1.o_step === 1'b1) && !prev1;
      rise4 = (bus4.o_step === 1'b1) && !prev4;
      prev1 = (bus1.o_step === 1'b1);
      prev4 = (bus4.o_step === 1'b1);
   endtask

   initial begin
      int         ramp_up[5];
      int         ramp_dn[4];
      int         nrise, seen, highs;
      longint     last_rise, measured;
      ramp_up = '{2, 4, 6, 7, 7};
      ramp_dn = '{5, 3, 1, 0};

      // reset state
      rst = 1'b1;
      cycle(); cycle();
      chk("rst_speed", bus1.o_speed, 0);
      chk("rst_step", bus4.o_step, 0);
      chk("rst_running", bus1.o_running, 0);
      chk("rst_at_target", bus1.o_at_target, 0);
      chk("rst_overrun", bus4.o_overrun, 0);

      // basic rate: speed 5, step 10 -> one pulse every 2 ticks
      rst = 1'b0; en = 1'b1; step_sz = 10; target = 5; accel = 0; tick = 1'b1;
      cycle();
      trig = 1'b1; cycle(); trig = 1'b0;
      chk("rate_speed", bus1.o_speed, 5);
      nrise = 0; last_rise = -1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (rise1) begin
            if (last_rise >= 0) chk("rate_period", cyc - last_rise, 2);
            last_rise = cyc;
            nrise++;
         end
      end
      chk("rate_count", nrise, 10);

      // ramp up and down
      frc = 1'b1; cycle(); frc = 1'b0;
      accel = 2; target = 7; tick = 1'b0;
      cycle();
      for (int k = 0; k < 5; k++) begin
         trig = 1'b1; cycle(); trig = 1'b0;
         chk("ramp_up_speed", bus1.o_speed, ramp_up[k]);
         chk("ramp_up_at_target", bus1.o_at_target, k >= 3);
         cycle();
      end
      en = 1'b0; cycle();
      for (int k = 0; k < 4; k++) begin
         trig = 1'b1; cycle(); trig = 1'b0;
         chk("ramp_dn_speed", bus1.o_speed, ramp_dn[k]);
         chk("ramp_dn_running", bus1.o_running, 1);
         cycle();
      end
      chk("stopped_running", bus1.o_running, 0);

      // force stop in the middle of a pulse
      en = 1'b1; target = 100; accel = 0; step_sz = 250; tick = 1'b1;
      cycle();
      trig = 1'b1; cycle(); trig = 1'b0;
      chk("fs_speed", bus4.o_speed, 100);
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         cycle();
         if (bus4.o_step === 1'b1) seen = 1;
      end
      chk("fs_pulse_seen", seen, 1);
      frc = 1'b1; cycle(); frc = 1'b0; en = 1'b0;
      chk("fs_step", bus4.o_step, 0);
      chk("fs_speed0", bus4.o_speed, 0);
      chk("fs_running", bus4.o_running, 0);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (bus1.o_step === 1'b1 || bus4.o_step === 1'b1) highs++;
      end
      chk("fs_no_pulses", highs, 0);

      // overrun: speed 12 with step 4 is faster than one pulse per tick
      en = 1'b1; step_sz = 4; target = 12; accel = 0; tick = 1'b1;
      cycle();
      trig = 1'b1; cycle(); trig = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("ovr_set", bus1.o_overrun, 1);
      en = 1'b0; cycle();
      chk("ovr_sticky_stopping", bus1.o_overrun, 1);
      en = 1'b1; cycle();
      chk("ovr_sticky_rerun", bus1.o_overrun, 1);
      en = 1'b0; cycle();
      trig = 1'b1; cycle(); trig = 1'b0;
      chk("ovr_speed0", bus1.o_speed, 0);
      cycle();
      chk("ovr_idle", bus1.o_running, 0);
      chk("ovr_sticky_idle", bus1.o_overrun, 1);
      en = 1'b1; cycle();
      chk("ovr_clear_pw1", bus1.o_overrun, 0);
      chk("ovr_clear_pw4", bus4.o_overrun, 0);

      // pulse collision on the width-4 generator: period 4+1
      step_sz = 1; target = 1;
      trig = 1'b1; cycle(); trig = 1'b0;
      nrise = 0; last_rise = -1;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (rise4) begin
            if (last_rise >= 0) chk("coll_period", cyc - last_rise, 5);
            last_rise = cyc;
            nrise++;
         end
      end
      chk("coll_count", nrise, 6);
      chk("coll_overrun", bus4.o_overrun, 1);

      // loopback: count pulses over a 100-tick window at speed 3, step 6
      step_sz = 6; target = 3;
      trig = 1'b1; cycle(); trig = 1'b0;
      nrise = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (rise1) nrise++;
      end
      measured = longint'(nrise) * 6;
      checks++;
      assert (measured >= 294 && measured <= 306) else begin
         errors++;
         $error("FAIL loopback measured=%0d expected=300+-6", measured);
      end

      // synchronous reset mid-run
      rst = 1'b1; cycle(); rst = 1'b0;
      chk("rst2_speed", bus1.o_speed, 0);
      chk("rst2_step1", bus1.o_step, 0);
      chk("rst2_step4", bus4.o_step, 0);
      chk("rst2_running", bus4.o_running, 0);
      chk("rst2_at_target", bus4.o_at_target, 0);
      chk("rst2_overrun", bus4.o_overrun, 0);

      // randomized operation against the model
      en = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         rst  = ($urandom_range(0, 299) == 0);
         frc  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 19) == 0) en = ~en;
         tick = ($urandom_range(0, 3) != 0);
         trig = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) target  = $urandom_range(0, 40);
         if ($urandom_range(0, 15) == 0) accel   = $urandom_range(0, 6);
         if ($urandom_range(0, 31) == 0) step_sz = $urandom_range(0, 20);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
